// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the wait-state APB memory completer
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int          APB_ADDR_W = 8;
  localparam int          APB_DATA_W = 32;
  localparam int          WAIT_W     = 4;
  localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - loadable down-counter that times the access-phase wait states
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset (count -> 0)
//   i_load           load i_load_val (takes priority over i_en)
//   i_load_val       value to load
//   i_en             decrement by one while the count is non-zero
//   o_done           count equals 1: the final wait cycle is in progress
module apb_wait_timer #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/apb_ws_mem_slave.sv
// rtl/apb_ws_mem_slave.sv - APB completer flop-array memory with programmable wait states
//
// Optional build macro: APB_WS_SLVERR_EN (error response on out-of-range or misaligned access)
//
// Ports:
//   PCLK, RESET     clock, synchronous active-high reset
//   PADDR           byte address; word index = PADDR[ADDR_W-1:2]
//   PSEL, PENABLE   APB select / access-phase marker
//   PWRITE, PWDATA  direction and write data
//   PRDATA          registered read data, non-zero only while PREADY=1
//   PREADY          one-cycle transfer-complete pulse
//   PSLVERR         error response qualified by PREADY (0 unless macro defined)
module apb_ws_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_pready;
  logic              r_pslverr;
  logic [DATA_W-1:0] r_prdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_setup;
  logic              w_start;
  logic              w_complete;
  logic              w_abort;
  logic              w_tmr_en;
  logic              w_tmr_done;
  logic              w_fire;
  logic              w_commit;
  logic [ADDR_W-1:0] w_addr_cur;
  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range;
  logic              w_err;
  logic              w_wr_ok;
  logic              w_wr_cur;
  logic [DATA_W-1:0] w_mem_rd;
  logic [DATA_W-1:0] w_rd_val;

  assign w_setup = PSEL && !PENABLE;

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        // PENABLE without a preceding setup cycle is not a setup: stay idle.
        if (w_setup) begin
          w_start     = 1'b1;
          w_state_nxt = (WAIT_CYCLES == 0) ? DONE : ACCESS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (PENABLE) begin
          w_tmr_en = 1'b1;
          if (w_tmr_done) begin
            w_complete  = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Abort reloads zero so a stale count never leaks into the next transfer.
  apb_wait_timer #(
    .CNT_W (WAIT_W)
  ) u_wait_timer (
    .i_clk      (PCLK),
    .i_reset    (RESET),
    .i_load     (w_start || w_abort),
    .i_load_val (w_start ? WAIT_W'(WAIT_CYCLES) : '0),
    .i_en       (w_tmr_en),
    .o_done     (w_tmr_done)
  );

  // A zero-wait transfer decodes the live bus on its setup edge; otherwise
  // the latched request is the one being served.
  assign w_addr_cur = w_start ? PADDR : r_addr;
  assign w_wr_cur   = w_start ? PWRITE : r_write;
  assign w_idx      = w_addr_cur[ADDR_W-1:2];
  assign w_in_range = ({{(32-IDX_W){1'b0}}, w_idx} < DEPTH);
  assign w_mem_rd   = w_in_range ? r_mem[w_idx[MEM_AW-1:0]] : '0;

`ifdef APB_WS_SLVERR_EN
  assign w_err    = !w_in_range || (w_addr_cur[1:0] != 2'b00);
  assign w_rd_val = w_err ? DATA_W'(ERR_RDATA) : w_mem_rd;
`else
  logic w_unused_addr_lo;
  assign w_unused_addr_lo = ^w_addr_cur[1:0];
  assign w_err            = 1'b0;
  assign w_rd_val         = w_mem_rd;
`endif

  assign w_wr_ok  = w_in_range && !w_err;
  assign w_fire   = (w_start && (WAIT_CYCLES == 0)) || w_complete;
  assign w_commit = (r_state == DONE) && PSEL && PENABLE && r_pready && r_write && w_wr_ok;

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= PADDR;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
      end
      // PREADY is a single-cycle pulse; everything returns to zero after it.
      if (w_fire) begin
        r_pready  <= 1'b1;
        r_prdata  <= w_wr_cur ? '0 : w_rd_val;
        r_pslverr <= w_err;
      end else begin
        r_pready  <= 1'b0;
        r_prdata  <= '0;
        r_pslverr <= 1'b0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      r_mem[w_idx[MEM_AW-1:0]] <= r_wdata;
    end
  end

  assign PREADY  = r_pready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_ws_mem_slave.sv
// tb/tb_apb_ws_mem_slave.sv - directed self-checking bench for apb_ws_mem_slave
module tb_apb_ws_mem_slave;

`ifdef APB_WS_SLVERR_EN
  localparam logic        E_ERR  = 1'b1;
  localparam logic [31:0] E_OOR  = 32'hDEAD_BEEF;
  localparam logic [31:0] E_MIS  = 32'hDEAD_BEEF;
`else
  localparam logic        E_ERR  = 1'b0;
  localparam logic [31:0] E_OOR  = 32'h0;
  localparam logic [31:0] E_MIS  = 32'h1111_1111;
`endif

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  paddr = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        psel_ws = 1'b0;
  logic        psel_zw = 1'b0;
  logic [31:0] prdata_ws, prdata_zw;
  logic        pready_ws, pready_zw, pslverr_ws, pslverr_zw;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_dbl = 0;
  logic prev_rdy = 1'b0;

  apb_ws_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(2)) u_dut_ws (
    .PCLK(pclk), .RESET(reset), .PADDR(paddr), .PSEL(psel_ws), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata_ws), .PREADY(pready_ws), .PSLVERR(pslverr_ws)
  );

  apb_ws_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut_zw (
    .PCLK(pclk), .RESET(reset), .PADDR(paddr), .PSEL(psel_zw), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata_zw), .PREADY(pready_zw), .PSLVERR(pslverr_zw)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc++;

  always @(negedge pclk) begin
    if (pready_ws && prev_rdy) n_dbl++;
    prev_rdy = pready_ws;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge pclk);
    #1;
  endtask

  // Entered just after a rising edge; returns just after the edge that ends
  // the access phase so another call can follow with no idle cycle.
  task automatic apb_xfer(input bit zw, input logic [7:0] a, input logic w, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int acc, output int rcyc);
    bit done = 0;
    psel_ws = !zw; psel_zw = zw; penable = 1'b0;
    paddr = a; pwrite = w; pwdata = wd;
    rd = 'x; err = 1'bx; acc = 0; rcyc = -1;
    sync();
    penable = 1'b1;
    while (!done && acc < 40) begin
      @(negedge pclk);
      acc++;
      if (zw ? pready_zw : pready_ws) begin
        rd = zw ? prdata_zw : prdata_ws;
        err = zw ? pslverr_zw : pslverr_ws;
        rcyc = cyc;
        done = 1;
      end
      sync();
    end
    psel_ws = 1'b0; psel_zw = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          acc, r0, r1, r2;

    repeat (3) @(posedge pclk);
    #1 reset = 1'b0;
    @(negedge pclk);
    chk("rst_pready_ws", 32'(pready_ws), 32'h0);
    chk("rst_prdata_ws", prdata_ws, 32'h0);
    chk("rst_pslverr_ws", 32'(pslverr_ws), 32'h0);
    chk("rst_pready_zw", 32'(pready_zw), 32'h0);

    sync();
    apb_xfer(1, 8'h04, 0, 0, rd, err, acc, r0);
    chk("zw_rd04_acc", acc, 1);
    chk("zw_rd04_data", rd, 32'h0);

    apb_xfer(0, 8'h10, 0, 0, rd, err, acc, r0);
    chk("rd10_acc", acc, 3);
    chk("rd10_data", rd, 32'h0);
    chk("rd10_err", 32'(err), 32'h0);
    @(negedge pclk);
    chk("rd10_prdata_after", prdata_ws, 32'h0);
    chk("rd10_pready_after", 32'(pready_ws), 32'h0);
    sync();

    apb_xfer(0, 8'h14, 1, 32'hA5A5_0001, rd, err, acc, r0);
    chk("wr14_acc", acc, 3);
    apb_xfer(0, 8'h14, 0, 0, rd, err, acc, r0);
    chk("rd14_acc", acc, 3);
    chk("rd14_data", rd, 32'hA5A5_0001);

    apb_xfer(0, 8'h00, 1, 32'h1111_1111, rd, err, acc, r0);
    apb_xfer(0, 8'h04, 1, 32'h2222_2222, rd, err, acc, r1);
    apb_xfer(0, 8'h08, 1, 32'h3333_3333, rd, err, acc, r2);
    chk("b2b_gap01", r1 - r0, 4);
    chk("b2b_gap12", r2 - r1, 4);
    apb_xfer(0, 8'h00, 0, 0, rd, err, acc, r0);
    chk("b2b_rd00", rd, 32'h1111_1111);
    apb_xfer(0, 8'h04, 0, 0, rd, err, acc, r0);
    chk("b2b_rd04", rd, 32'h2222_2222);
    apb_xfer(0, 8'h08, 0, 0, rd, err, acc, r0);
    chk("b2b_rd08", rd, 32'h3333_3333);
    chk("b2b_rd08_acc", acc, 3);

    apb_xfer(1, 8'h04, 1, 32'hCAFE_0004, rd, err, acc, r0);
    chk("zw_wr04_acc", acc, 1);
    apb_xfer(1, 8'h04, 0, 0, rd, err, acc, r0);
    chk("zw_rd04b_data", rd, 32'hCAFE_0004);

    psel_ws = 1'b1; penable = 1'b1; paddr = 8'h00; pwrite = 1'b1; pwdata = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("noset_pready", 32'(pready_ws), 32'h0);
    end
    sync();
    psel_ws = 1'b0; penable = 1'b0;
    sync();

    psel_ws = 1'b1; penable = 1'b0; paddr = 8'h00; pwrite = 1'b1; pwdata = 32'hDEAD_DEAD;
    sync();
    penable = 1'b1;
    sync();
    psel_ws = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("abort_pready", 32'(pready_ws), 32'h0);
    end
    sync();
    apb_xfer(0, 8'h00, 0, 0, rd, err, acc, r0);
    chk("abort_rd00", rd, 32'h1111_1111);

    apb_xfer(0, 8'h40, 1, 32'h5555_5555, rd, err, acc, r0);
    chk("wr40_acc", acc, 3);
    chk("wr40_err", 32'(err), 32'(E_ERR));
    apb_xfer(0, 8'h40, 0, 0, rd, err, acc, r0);
    chk("rd40_err", 32'(err), 32'(E_ERR));
    chk("rd40_data", rd, E_OOR);
    apb_xfer(0, 8'h00, 0, 0, rd, err, acc, r0);
    chk("rd00_noalias", rd, 32'h1111_1111);
    chk("rd00_err", 32'(err), 32'h0);
    apb_xfer(0, 8'h02, 0, 0, rd, err, acc, r0);
    chk("rd02_err", 32'(err), 32'(E_ERR));
    chk("rd02_data", rd, E_MIS);

    psel_ws = 1'b1; penable = 1'b0; paddr = 8'h20; pwrite = 1'b1; pwdata = 32'h1234_5678;
    sync();
    penable = 1'b1;
    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0; psel_ws = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("rstmid_pready", 32'(pready_ws), 32'h0);
    sync();
    apb_xfer(0, 8'h20, 0, 0, rd, err, acc, r0);
    chk("rstmid_rd20", rd, 32'h0);
    chk("rstmid_acc", acc, 3);

    chk("pready_double", n_dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
